// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions used by the fetch stage: reset vector,
// fetch entry layout, fetch modes and PC arithmetic.
package rv32i_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        logic        misaligned;
    } fetch_entry_t;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } fetch_mode_e;

    // Sequential PC; 32'hFFFF_FFFC wraps to 0 by plain modular addition.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush. The head is read straight
// from the slot registers, so a push is visible at the output the next cycle.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output logic          head_valid,
    output fetch_entry_t  head_entry,
    output logic [CW-1:0] occupancy
);

    fetch_entry_t  slots [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [AW-1:0] wr_idx;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push that coincides with a flush restarts the buffer at slot 0.
    assign wr_idx = flush ? '0 : wr_ptr_reg;
    assign do_pop = pop && (count_reg != '0) && !flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            fetch_entry_t slot_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (push && (wr_idx == AW'(gi))) begin
                    slot_reg <= push_entry;
                end
            end

            assign slots[gi] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= push ? AW'(1) : '0;
            count_reg  <= push ? CW'(1) : '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CW'(push) - CW'(do_pop);
        end
    end

    assign head_valid = (count_reg != '0);
    assign head_entry = slots[rd_ptr_reg];
    assign occupancy  = count_reg;

    // The request credit scheme upstream must make this unreachable.
    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && !do_pop && (count_reg == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: PC, credit-limited in-order memory requests,
// redirect/flush handling and in-band fault reporting to decode.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        fetch_err,
    output logic        fetch_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc_reg, pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_reg, drop_next;
    fetch_mode_e   mode_reg, mode_next;

    logic          pop;
    logic          req_fire;
    logic [CW:0]   credit_used;
    logic [31:0]   rsp_pc;
    logic          fifo_push;
    logic          fifo_flush;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic          head_valid;
    logic [CW-1:0] occupancy;

    assign pop = head_valid && fetch_ready;

    // Buffered entries plus in-flight requests must fit in the FIFO.
    assign credit_used = (CW+1)'(outstanding_reg) + (CW+1)'(occupancy) - (CW+1)'(pop);

    assign imem_req_valid = !rst && (mode_reg == MODE_RUN) && !redirect_valid
                            && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Once drop reaches zero every outstanding request was issued
    // back-to-back since the last redirect, ending at pc_reg - 4, so the
    // oldest one sits outstanding_reg words behind pc_reg.
    assign rsp_pc = pc_reg - (32'(outstanding_reg) << 2);

    always_comb begin
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_next        = drop_reg;
        pc_next          = req_fire ? pc_plus4(pc_reg) : pc_reg;
        mode_next        = mode_reg;
        fifo_push        = 1'b0;
        fifo_flush       = 1'b0;
        push_entry       = '0;

        if (imem_rsp_valid && (drop_reg != '0)) begin
            drop_next = drop_reg - CW'(1);
        end

        if (redirect_valid) begin
            // Everything still in flight, bar a response landing now, is stale.
            fifo_flush = 1'b1;
            drop_next  = outstanding_next;
            pc_next    = redirect_pc;
            mode_next  = MODE_RUN;
            if (redirect_pc[1:0] != 2'b00) begin
                fifo_push             = 1'b1;
                push_entry.pc         = redirect_pc;
                push_entry.misaligned = 1'b1;
                mode_next             = MODE_HALT;
            end
        end else if (imem_rsp_valid && (drop_reg == '0)) begin
            fifo_push        = 1'b1;
            push_entry.pc    = rsp_pc;
            push_entry.instr = imem_rsp_err ? '0 : imem_rsp_data;
            push_entry.err   = imem_rsp_err;
            if (imem_rsp_err) begin
                mode_next = MODE_HALT;
                drop_next = outstanding_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            mode_reg        <= MODE_RUN;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            mode_reg        <= mode_next;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (fifo_flush),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .occupancy  (occupancy)
    );

    assign fetch_valid      = head_valid;
    assign fetch_instr      = head_entry.instr;
    assign fetch_pc         = head_entry.pc;
    assign fetch_err        = head_valid && head_entry.err;
    assign fetch_misaligned = head_valid && head_entry.misaligned;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RV32I core, directly upstream of instruction decode. Holds the PC, issues in-order word requests to instruction memory over a valid/ready request channel, and buffers returned words with their PCs in a small FIFO presented to decode over a valid/ready handshake. Accepts redirects from execute (taken branch, JAL, JALR), flushes buffered and in-flight fetches, and reports misaligned-target and memory access faults in-band.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- FIFO_DEPTH, 2, fetch buffer entries; also the credit limit on outstanding requests (≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset; also resets instruction memory
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address (bits [1:0] always 0 when valid)
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, no backpressure
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault for this response
- redirect_valid  in  1  one-cycle redirect pulse from execute
- redirect_pc  in  32  redirect target
- fetch_valid  out  1  FIFO head valid to decode
- fetch_ready  in  1  decode consumes head
- fetch_instr  out  32  instruction word (0 on fault entries)
- fetch_pc  out  32  PC of instruction
- fetch_err  out  1  access fault entry
- fetch_misaligned  out  1  misaligned-target entry

## Operation
- State: pc, outstanding counter (0..FIFO_DEPTH), drop counter (0..FIFO_DEPTH), FIFO, mode ∈ {RUN, HALT}.
- Reset values: pc=RESET_PC, mode=RUN, FIFO empty, counters 0; fetch_valid=0, imem_req_valid=0 while rst=1, fetch_err=fetch_misaligned=0.
- Request: imem_req_valid = !rst & mode==RUN & !redirect_valid & (outstanding + occupancy − pop < FIFO_DEPTH), where pop = fetch_valid & fetch_ready. imem_req_addr = pc. On acceptance pc += 4 (wraps 32'hFFFF_FFFC→0), outstanding++.
- Valid/address may drop or change without acceptance (redirect); memory must tolerate this.
- Response: outstanding--. If drop>0: discard, drop--. Else push {pc_of_request, data, err, 0}. Credit guarantees FIFO never overflows; overflow is a design error (assertion).
- Request PCs are tracked by a tag queue alongside outstanding entries, or equivalently recomputed from FIFO tail PC + 4.
- Error response pushed → mode=HALT, drop = remaining outstanding; no further requests.
- Redirect (any mode, highest priority): FIFO flushed, drop = outstanding after this cycle's response accounting (a response arriving in the redirect cycle is discarded), mode=RUN, pc=redirect_pc.
  - If redirect_pc[1:0]≠0: push single entry {redirect_pc, 0, err=0, misaligned=1}, mode=HALT.
- HALT exits only on redirect or rst.
- Simultaneous pop and push: both occur; occupancy unchanged.

## Timing
- Request accepted cycle N; response earliest N+1; entry visible on fetch_valid at N+2 (one registered FIFO stage).
- Steady state with 1-cycle memory and fetch_ready=1: one instruction per cycle.
- Redirect cycle R: fetch_valid=0 at R+1; first new request at R+1; first new instruction earliest R+3. Misaligned entry visible at R+1.
- FIFO outputs are registered; fetch_* stable while fetch_valid & !fetch_ready.
- rst mid-operation: next cycle all outputs at reset values; first request to RESET_PC in first cycle with rst=0.

## Structure
- Shared package rv32i_pkg: RESET_PC default, fetch entry typedef {pc, instr, err, misaligned}, INSTR_NOP constant.
- Sub-module fetch_fifo: synchronous FIFO of fetch entries, parameterized depth, push/pop/flush, registered head, occupancy output.
- Top: PC, counters, mode FSM, request logic.

## Test plan
- Reset, 1-cycle memory, fetch_ready=1 → requests 0x0,0x4,0x8…; fetch_pc 0x0 at cycle 2 post-reset, then one per cycle, instr matches memory.
- fetch_ready=0 for 6 cycles → at most 2 entries + 0 outstanding, no requests beyond credit, order 0x0,0x4 preserved after release.
- Redirect to 0x100 with 1 outstanding response (addr 0x8) → 0x8 data discarded, next fetch_pc=0x100, then 0x104.
- Redirect to 0x102 → one entry pc=0x102, misaligned=1, instr=0; no imem_req_valid until redirect to 0x200.
- Response to 0x10 with imem_rsp_err=1 → entry err=1 pc=0x10, HALT, later response for 0x14 discarded; no requests until redirect.
- rst asserted with 2 entries buffered → fetch_valid=0 next cycle; after release, first request addr=RESET_PC.
